// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the data memory slice: state encoding,
//               word/address/lane widths, LATENCY bounds, alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int c_word_w  = 32;            // data word width
    localparam int c_addr_w  = 32;            // CPU byte-address width
    localparam int c_lanes   = c_word_w / 8;  // byte lanes per word
    localparam int c_lat_min = 1;             // smallest legal LATENCY
    localparam int c_lat_max = 15;            // largest legal LATENCY
    localparam int c_cnt_w   = 4;             // counter holds LATENCY-1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    // A word access is misaligned when either low byte-address bit is set.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_if
// Description : CPU-side bus of the data memory.
//               master : drives req_i, we_i, addr_i, wdata_i, be_i
//               slave  : drives ack_o, rdata_o, busy_o, err_o
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_if;
    import dmem_pkg::*;

    logic                  req_i;
    logic                  we_i;
    logic [c_addr_w-1:0]   addr_i;
    logic [c_word_w-1:0]   wdata_i;
    logic [c_lanes-1:0]    be_i;
    logic                  ack_o;
    logic [c_word_w-1:0]   rdata_o;
    logic                  busy_o;
    logic                  err_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i, be_i,
        input  ack_o, rdata_o, busy_o, err_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, be_i,
        output ack_o, rdata_o, busy_o, err_o
    );

endinterface
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_array
// Description : 2**ADDR_WIDTH x 32-bit storage. Synchronous write with one
//               enable per byte lane, combinational read of the same word.
//               Contents are never reset.
// Ports       : clk_i   - clock
//               we_i    - per-lane write enables
//               addr_i  - word index
//               wdata_i - write data
//               rdata_o - word currently addressed
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  wire logic                  clk_i,
    input  wire logic [c_lanes-1:0]    we_i,
    input  wire logic [ADDR_WIDTH-1:0] addr_i,
    input  wire logic [c_word_w-1:0]   wdata_i,
    output logic      [c_word_w-1:0]   rdata_o
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [c_word_w-1:0] r_mem [c_depth];

    always_ff @(posedge clk_i) begin
        for (int lane = 0; lane < c_lanes; lane++) begin
            if (we_i[lane]) begin
                r_mem[addr_i][8*lane +: 8] <= wdata_i[8*lane +: 8];
            end
        end
    end

    assign rdata_o = r_mem[addr_i];

endmodule
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Fixed-latency CPU data memory. A request is taken in IDLE,
//               waits in WAIT, and completes with a one-cycle ack_o in RESP.
//               The accepting edge counts as the first latency cycle, so ack_o
//               is visible LATENCY-1 edges after acceptance and the peak rate
//               is one access per LATENCY+1 cycles.
// Ports       : clk_i - clock (rising edge)
//               rst_i - synchronous active-high reset
//               bus   - data_memory_if.slave (req/we/addr/wdata/be in,
//                       ack/rdata/busy/err out)
// Config      : DMEM_BYTE_STROBE_EN - when defined, stores honour be_i;
//               otherwise every store writes the full word.
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int LATENCY    = 3
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    data_memory_if.slave bus
);

    localparam logic [1:0] c_idle = ST_IDLE;
    localparam logic [1:0] c_wait = ST_WAIT;
    localparam logic [1:0] c_resp = ST_RESP;

    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(LATENCY - 1);
    // With LATENCY=1 there is no WAIT phase: the access happens on the
    // accepting edge and RESP follows immediately.
    localparam bit c_direct = (LATENCY == 1);

    generate
        if (LATENCY < c_lat_min || LATENCY > c_lat_max) begin : g_bad_latency
            $error("data_memory: LATENCY out of range 1..15");
        end
    endgenerate

    logic [1:0]            r_state;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_we;
    logic                  r_mis;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [c_word_w-1:0]   r_wdata;
    logic [c_word_w-1:0]   r_rdata;
    logic                  r_err;

    logic                  w_idle;
    logic                  w_access;
    logic                  w_op_we;
    logic                  w_op_mis;
    logic [ADDR_WIDTH-1:0] w_op_idx;
    logic [c_word_w-1:0]   w_op_wdata;
    logic                  w_store;
    logic [c_lanes-1:0]    w_lane_we;
    logic [c_word_w-1:0]   w_rd_word;
    logic                  w_unused_addr;

    assign w_idle = (r_state == c_idle);

    // The access fires on the edge that moves the FSM into RESP: either the
    // last WAIT cycle (counter about to reach zero) or, for LATENCY=1, the
    // accepting edge itself.
    assign w_access = (c_direct && w_idle && bus.req_i) ||
                      (r_state == c_wait && r_cnt == c_cnt_w'(1));

    // On the accepting edge the latched copies are not yet valid, so the
    // operands come straight from the bus there.
    assign w_op_we    = w_idle ? bus.we_i : r_we;
    assign w_op_mis   = w_idle ? is_misaligned(bus.addr_i[1:0]) : r_mis;
    assign w_op_idx   = w_idle ? bus.addr_i[ADDR_WIDTH+1:2] : r_widx;
    assign w_op_wdata = w_idle ? bus.wdata_i : r_wdata;

    // Reset on the access edge abandons the store.
    assign w_store = w_access && w_op_we && !w_op_mis && !rst_i;

`ifdef DMEM_BYTE_STROBE_EN
    logic [c_lanes-1:0] r_be;
    logic [c_lanes-1:0] w_op_be;

    assign w_op_be   = w_idle ? bus.be_i : r_be;
    assign w_lane_we = {c_lanes{w_store}} & w_op_be;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_be <= '0;
        end else if (w_idle && bus.req_i) begin
            r_be <= bus.be_i;
        end
    end

    assign w_unused_addr = ^bus.addr_i;
`else
    assign w_lane_we     = {c_lanes{w_store}};
    assign w_unused_addr = ^{bus.addr_i, bus.be_i};
`endif

    dmem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (w_lane_we),
        .addr_i  (w_op_idx),
        .wdata_i (w_op_wdata),
        .rdata_o (w_rd_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_idle;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_mis   <= 1'b0;
            r_widx  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (bus.req_i) begin
                        r_we    <= bus.we_i;
                        r_mis   <= is_misaligned(bus.addr_i[1:0]);
                        r_widx  <= bus.addr_i[ADDR_WIDTH+1:2];
                        r_wdata <= bus.wdata_i;
                        r_cnt   <= c_cnt_load;
                        r_state <= c_direct ? c_resp : c_wait;
                    end
                end
                c_wait: begin
                    r_cnt <= r_cnt - c_cnt_w'(1);
                    if (r_cnt == c_cnt_w'(1)) begin
                        r_state <= c_resp;
                    end
                end
                c_resp: begin
                    r_state <= c_idle;
                end
                default: begin
                    r_state <= c_idle;
                end
            endcase

            // Response data: loads capture the word, misaligned accesses
            // force zero, aligned stores leave rdata_o untouched.
            if (w_access) begin
                r_err <= w_op_mis;
                if (w_op_mis) begin
                    r_rdata <= '0;
                end else if (!w_op_we) begin
                    r_rdata <= w_rd_word;
                end
            end
        end
    end

    assign bus.ack_o   = (r_state == c_resp);
    assign bus.busy_o  = !w_idle;
    assign bus.err_o   = (r_state == c_resp) && r_err;
    assign bus.rdata_o = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Self-checking bench for data_memory. Two instances: dut0
//               (LATENCY=3) and dut1 (LATENCY=1), both ADDR_WIDTH=8. An
//               edge-numbered reference model predicts ack/busy/err/rdata
//               every cycle; directed vectors add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_memory_if if0 ();
    data_memory_if if1 ();

    logic        req_d   [2];
    logic        we_d    [2];
    logic [31:0] addr_d  [2];
    logic [31:0] wdata_d [2];
    logic [3:0]  be_d    [2];
    logic        ack_s   [2];
    logic        busy_s  [2];
    logic        err_s   [2];
    logic [31:0] rdata_s [2];

    assign if0.req_i = req_d[0];   assign if1.req_i = req_d[1];
    assign if0.we_i = we_d[0];     assign if1.we_i = we_d[1];
    assign if0.addr_i = addr_d[0]; assign if1.addr_i = addr_d[1];
    assign if0.wdata_i = wdata_d[0]; assign if1.wdata_i = wdata_d[1];
    assign if0.be_i = be_d[0];     assign if1.be_i = be_d[1];
    assign ack_s[0] = if0.ack_o;   assign ack_s[1] = if1.ack_o;
    assign busy_s[0] = if0.busy_o; assign busy_s[1] = if1.busy_o;
    assign err_s[0] = if0.err_o;   assign err_s[1] = if1.err_o;
    assign rdata_s[0] = if0.rdata_o; assign rdata_s[1] = if1.rdata_o;

    data_memory #(.ADDR_WIDTH(8), .LATENCY(3)) dut (
        .clk_i (clk), .rst_i (rst), .bus (if0)
    );
    data_memory #(.ADDR_WIDTH(8), .LATENCY(1)) dut_l1 (
        .clk_i (clk), .rst_i (rst), .bus (if1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int d,
                         input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h, expected %h", name, d, $time, got, want);
        end
    endtask

    function automatic int lat_of(input int d);
        return (d == 0) ? 3 : 1;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
`ifdef DMEM_BYTE_STROBE_EN
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
`else
        return 32'hFFFF_FFFF | {32{^be}};
`endif
    endfunction

    // ---------------- reference model ----------------
    // Accept at edge P; ack visible after edge P+L-1 (memory updated on
    // that edge); back to idle at edge P+L.
    int unsigned edge_n = 0;
    bit          seen_rst = 1'b0;
    logic        m_act    [2] = '{default: 1'b0};
    int unsigned m_ack_at [2] = '{default: 0};
    logic        m_we     [2];
    logic        m_mis    [2];
    logic [7:0]  m_idx    [2];
    logic [31:0] m_wd     [2];
    logic [3:0]  m_be     [2];
    logic [31:0] m_mem    [2][256];
    logic        m_known  [2][256] = '{default: '{default: 1'b0}};
    logic [31:0] exp_rd   [2] = '{default: 32'h0};
    logic        rd_known [2] = '{default: 1'b0};
    logic        exp_err  [2] = '{default: 1'b0};

    always @(posedge clk) begin
        edge_n <= edge_n + 1;
        if (rst) seen_rst <= 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_act[d]    <= 1'b0;
                exp_rd[d]   <= 32'h0;
                rd_known[d] <= 1'b1;
                exp_err[d]  <= 1'b0;
            end else if (m_act[d]) begin
                if (edge_n + 1 == m_ack_at[d] + 1) begin
                    m_act[d] <= 1'b0;
                end else if (edge_n + 1 == m_ack_at[d]) begin
                    exp_err[d] <= m_mis[d];
                    if (m_mis[d]) begin
                        exp_rd[d] <= 32'h0; rd_known[d] <= 1'b1;
                    end else if (m_we[d]) begin
                        m_mem[d][m_idx[d]] <= (m_mem[d][m_idx[d]] & ~lane_mask(m_be[d]))
                                            | (m_wd[d] & lane_mask(m_be[d]));
                        m_known[d][m_idx[d]] <= m_known[d][m_idx[d]]
                                              | (lane_mask(m_be[d]) == 32'hFFFF_FFFF);
                    end else begin
                        exp_rd[d] <= m_mem[d][m_idx[d]]; rd_known[d] <= m_known[d][m_idx[d]];
                    end
                end
            end else if (req_d[d]) begin
                m_act[d]    <= 1'b1;
                m_ack_at[d] <= edge_n + lat_of(d);
                m_we[d]     <= we_d[d];
                m_mis[d]    <= (addr_d[d][1:0] != 2'b00);
                m_idx[d]    <= addr_d[d][9:2];
                m_wd[d]     <= wdata_d[d];
                m_be[d]     <= be_d[d];
                if (lat_of(d) == 1) begin
                    exp_err[d] <= (addr_d[d][1:0] != 2'b00);
                    if (addr_d[d][1:0] != 2'b00) begin
                        exp_rd[d] <= 32'h0; rd_known[d] <= 1'b1;
                    end else if (we_d[d]) begin
                        m_mem[d][addr_d[d][9:2]] <= (m_mem[d][addr_d[d][9:2]] & ~lane_mask(be_d[d]))
                                                  | (wdata_d[d] & lane_mask(be_d[d]));
                        m_known[d][addr_d[d][9:2]] <= m_known[d][addr_d[d][9:2]]
                                                    | (lane_mask(be_d[d]) == 32'hFFFF_FFFF);
                    end else begin
                        exp_rd[d] <= m_mem[d][addr_d[d][9:2]];
                        rd_known[d] <= m_known[d][addr_d[d][9:2]];
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (seen_rst) begin
            for (int d = 0; d < 2; d++) begin
                check("ack", d, {31'b0, ack_s[d]},
                      {31'b0, m_act[d] && (edge_n == m_ack_at[d])});
                check("busy", d, {31'b0, busy_s[d]}, {31'b0, m_act[d]});
                if (m_act[d] && edge_n == m_ack_at[d])
                    check("err", d, {31'b0, err_s[d]}, {31'b0, exp_err[d]});
                if (rd_known[d])
                    check("rdata", d, rdata_s[d], exp_rd[d]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be,
                          output logic [31:0] rd, output logic er, output int lat);
        bit found;
        @(negedge clk);
        req_d[d] = 1'b1; we_d[d] = we; addr_d[d] = addr; wdata_d[d] = wd; be_d[d] = be;
        @(posedge clk);
        @(negedge clk);
        req_d[d] = 1'b0;
        found = 1'b0;
        lat = 1;
        while (!found && lat <= 20) begin
            if (ack_s[d]) found = 1'b1;
            else begin
                @(posedge clk); @(negedge clk);
                lat++;
            end
        end
        if (!found) begin
            check("ack_timeout", d, 32'd0, 32'd1);
            lat = 0;
        end
        rd = rdata_s[d];
        er = err_s[d];
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n_ack, n_idle, first_ack, second_ack;

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_d[d] = 1'b0; we_d[d] = 1'b0; addr_d[d] = 32'h0;
            wdata_d[d] = 32'h0; be_d[d] = 4'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ack", 0, {31'b0, ack_s[0]}, 32'd0);
        check("reset_busy", 0, {31'b0, busy_s[0]}, 32'd0);
        check("reset_err", 0, {31'b0, err_s[0]}, 32'd0);
        check("reset_rdata", 0, rdata_s[0], 32'd0);
        rst = 1'b0;

        // Store then load at 0x10
        access(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        check("store_lat", 0, lat, 3);
        check("store_err", 0, {31'b0, er}, 32'd0);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("load_lat", 0, lat, 3);
        check("load_data", 0, rd, 32'hDEAD_BEEF);
        check("load_err", 0, {31'b0, er}, 32'd0);

        // Misaligned load
        access(0, 1'b0, 32'h12, 32'h0, 4'hF, rd, er, lat);
        check("mis_load_err", 0, {31'b0, er}, 32'd1);
        check("mis_load_data", 0, rd, 32'h0);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("after_mis_data", 0, rd, 32'hDEAD_BEEF);

        // Misaligned store into the same word must not write
        access(0, 1'b1, 32'h13, 32'h5555_5555, 4'hF, rd, er, lat);
        check("mis_store_err", 0, {31'b0, er}, 32'd1);
        access(0, 1'b0, 32'h10, 32'h0, 4'hF, rd, er, lat);
        check("mis_store_nowrite", 0, rd, 32'hDEAD_BEEF);

        // Continuous request: one ack every LATENCY+1 = 4 cycles
        @(negedge clk);
        req_d[0] = 1'b1; we_d[0] = 1'b0; addr_d[0] = 32'h10;
        n_ack = 0; n_idle = 0; first_ack = -1; second_ack = -1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); @(negedge clk);
            if (ack_s[0]) begin
                n_ack++;
                if (first_ack < 0) first_ack = i;
                else if (second_ack < 0) second_ack = i;
            end
            if (!busy_s[0]) n_idle++;
        end
        req_d[0] = 1'b0;
        check("stream_acks", 0, n_ack, 4);
        check("stream_idle", 0, n_idle, 4);
        check("stream_spacing", 0, second_ack - first_ack, 4);

        // Reset during WAIT of a store abandons it
        access(0, 1'b1, 32'h20, 32'h0BAD_F00D, 4'hF, rd, er, lat);
        @(negedge clk);
        req_d[0] = 1'b1; we_d[0] = 1'b1; addr_d[0] = 32'h20; wdata_d[0] = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        req_d[0] = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy", 0, {31'b0, busy_s[0]}, 32'd0);
        check("rst_mid_rdata", 0, rdata_s[0], 32'd0);
        n_ack = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); @(negedge clk);
            if (ack_s[0]) n_ack++;
        end
        check("rst_mid_noack", 0, n_ack, 0);
        access(0, 1'b0, 32'h20, 32'h0, 4'hF, rd, er, lat);
        check("rst_mid_prior", 0, rd, 32'h0BAD_F00D);

        // Byte strobes
        access(0, 1'b1, 32'h30, 32'hAABB_CCDD, 4'hF, rd, er, lat);
        access(0, 1'b1, 32'h30, 32'h1122_3344, 4'b0101, rd, er, lat);
        access(0, 1'b0, 32'h30, 32'h0, 4'hF, rd, er, lat);
`ifdef DMEM_BYTE_STROBE_EN
        check("strobe_merge", 0, rd, 32'hAA22_CC44);
`else
        check("strobe_ignored", 0, rd, 32'h1122_3344);
`endif

        // LATENCY=1 instance: address wrap-around
        access(1, 1'b1, 32'h400, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        check("l1_store_lat", 1, lat, 1);
        check("l1_store_err", 1, {31'b0, er}, 32'd0);
        access(1, 1'b0, 32'h000, 32'h0, 4'hF, rd, er, lat);
        check("l1_load_lat", 1, lat, 1);
        check("l1_wrap_data", 1, rd, 32'hCAFE_F00D);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
